// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default operand width.
package serial_add_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder built from two half-add stages and an OR; purely combinational.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  assign s1 = a ^ b;
  assign c1 = a & b;
  assign s  = s1 ^ cin;
  assign c2 = s1 & cin;
  assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-add cell sequenced LSB first, one bit per clock.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t         state_q;
  state_t         state_d;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic           carry_q;
  logic [CW-1:0]  cnt_q;
  logic           last_c;
  logic           fa_s;
  logic           fa_co;

  assign last_c = (cnt_q == CW'(WIDTH - 1));

  fa_cell u_fa (
    .a   (opa_q[0]),
    .b   (opb_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand shifters, carry flop, bit counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_q != IDLE);
      done <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            opa_q   <= a;
            opb_q   <= b;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
          end
        end
        RUN: begin
          opa_q      <= opa_q >> 1;
          opb_q      <= opb_q >> 1;
          carry_q    <= fa_co;
          sum[cnt_q] <= fa_s;
          // Counter saturates on the final bit so it never exceeds WIDTH-1
          if (last_c) cout  <= fa_co;
          else        cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
